// File: rtl/lvds_tx_pkg.sv
// Shared definitions for the LVDS transmit arbiter: FSM states and line levels.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lvds_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/lvds_tx_ser.sv
// Frame shifter: loads {stop, data, start}, shifts LSB first, one bit every DIV cycles.
// Latency: tx_bit shows the start bit in the cycle after load.
// Backpressure: none; the owner must only load when the previous frame is finished.
module lvds_tx_ser
    import lvds_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             tx_bit,
    output logic             last_cycle
);

    localparam int FW = WIDTH + 2;

    logic [FW-1:0] sr_q, sr_d;

    // Bit-period divider; with DIV=1 every cycle is the last of its bit.
    generate
        if (DIV == 1) begin : g_nodiv
            assign last_cycle = 1'b1;
        end else begin : g_div
            localparam int DW = $clog2(DIV);
            logic [DW-1:0] div_q, div_d;

            // Restart the bit period on load, wrap to 0 after DIV-1.
            always_comb begin
                div_d = div_q + 1'b1;
                if (load || (div_q == DW'(DIV - 1))) begin
                    div_d = '0;
                end
            end

            // Divider register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    div_q <= '0;
                end else begin
                    div_q <= div_d;
                end
            end

            assign last_cycle = (div_q == DW'(DIV - 1));
        end
    endgenerate

    // Load a fresh frame or shift idle level in behind the outgoing bit.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = {STOP_BIT, data, START_BIT};
        end else if (last_cycle) begin
            sr_d = {IDLE_LEVEL, sr_q[FW-1:1]};
        end
    end

    // Shift register; reset to all idle level so the line reads 1 immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= {FW{IDLE_LEVEL}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign tx_bit = sr_q[0];

endmodule

// File: rtl/lvds_tx_arbiter.sv
// Round-robin arbiter sharing one LVDS lane between NREQ requesters, framing each word.
// Latency: start bit in the cycle after accept; frame lasts (WIDTH+2)*DIV cycles.
// Backpressure: req_ready pulses only in IDLE or the last STOP cycle; other requests wait.
module lvds_tx_arbiter
    import lvds_tx_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      tx_bit,
    output logic                      tx_active,
    output logic [$clog2(NREQ)-1:0]   grant_id
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    tx_state_t        state_q;
    logic [CW-1:0]    bit_cnt_q;
    logic [GW-1:0]    grant_q;
    logic [GW-1:0]    last_grant_q;
    logic             active_q;

    logic [GW-1:0]    cand;
    logic [GW-1:0]    win;
    logic             win_vld;
    logic [WIDTH-1:0] win_data;
    logic             bit_last;
    logic             accept_en;
    logic             accept;

    // Round-robin search starting one past the last grant, wrapping at NREQ-1.
    always_comb begin
        cand    = last_grant_q;
        win     = '0;
        win_vld = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            cand = (cand == GW'(NREQ - 1)) ? '0 : cand + 1'b1;
            if (!win_vld && req_valid[cand]) begin
                win_vld = 1'b1;
                win     = cand;
            end
        end
    end

    // Select the winner's word for the serializer.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (GW'(i) == win) begin
                win_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Accept window is IDLE or the final STOP cycle, which gives zero-gap back-to-back frames.
    assign accept_en = (state_q == IDLE) || ((state_q == STOP) && bit_last);
    assign accept    = accept_en && win_vld && !rst;

    // One-hot ready strobe for the winner in the accept cycle.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win] = 1'b1;
        end
    end

    // Frame sequencing FSM with registered grant and activity outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            grant_q      <= '0;
            last_grant_q <= GW'(NREQ - 1);
            active_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q      <= START;
                        active_q     <= 1'b1;
                        grant_q      <= win;
                        last_grant_q <= win;
                    end
                end
                START: begin
                    if (bit_last) begin
                        state_q   <= DATA;
                        bit_cnt_q <= '0;
                    end
                end
                DATA: begin
                    if (bit_last) begin
                        if (bit_cnt_q == CW'(WIDTH - 1)) begin
                            state_q <= STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (bit_last) begin
                        if (accept) begin
                            state_q      <= START;
                            grant_q      <= win;
                            last_grant_q <= win;
                        end else begin
                            state_q  <= IDLE;
                            active_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    lvds_tx_ser #(
        .WIDTH (WIDTH),
        .DIV   (DIV)
    ) u_ser (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .data       (win_data),
        .tx_bit     (tx_bit),
        .last_cycle (bit_last)
    );

    assign tx_active = active_q;
    assign grant_id  = grant_q;

endmodule

// File: doc/lvds_tx_arbiter.md
LVDS_TX_ARBITER -- requirements
Module: lvds_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2: number of requesters sharing the one LVDS lane, legal range 2..8.
REQ-002 SHALL have parameter WIDTH, default 8: payload bits per frame, legal range 1..16.
REQ-003 SHALL have parameter DIV, default 4: clk cycles per serial bit, legal range 1..256.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, NREQ bits: requester i has a word pending.
REQ-007 SHALL have port req_data, input, NREQ*WIDTH bits: requester i's word is in bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_ready, output, NREQ bits: one-hot accept strobe.
REQ-009 SHALL have port tx_bit, output, 1 bit: serial line, driving the LVDS output buffer A input.
REQ-010 SHALL have port tx_active, output, 1 bit: a frame is on the line.
REQ-011 SHALL have port grant_id, output, clog2(NREQ) bits: index of the requester that owns the current frame.

Function
REQ-012 SHALL send each frame as: start bit 0, then WIDTH data bits LSB first, then stop bit 1; every bit is held exactly DIV cycles.
REQ-013 SHALL drive tx_bit=1 whenever no frame is active.
REQ-014 SHALL use FSM states IDLE, START, DATA, STOP. Transitions: IDLE->START on accept; START->DATA after DIV cycles; DATA->STOP after WIDTH*DIV cycles; STOP->START if an accept occurs in the last STOP cycle, otherwise STOP->IDLE.
REQ-015 SHALL arbitrate only in IDLE and in the last cycle of STOP, so back-to-back frames have zero idle gap.
REQ-016 SHALL arbitrate round-robin: search starts at (last_grant+1) mod NREQ; the first asserted req_valid wins.
REQ-017 SHALL assert req_ready[winner] for exactly one cycle, in the accept cycle; a transfer is valid&ready, and req_data is captured in that cycle only.
REQ-018 SHALL drive tx_bit=0 (start bit) in the cycle after accept; tx_active SHALL be high from that cycle through the last STOP cycle.
REQ-019 SHALL update grant_id in the cycle after accept and hold it until the next accept.
REQ-020 SHALL NOT accept while START or DATA is active, nor in STOP cycles other than the last; req_valid deasserted before accept SHALL be dropped with no side effect.
REQ-021 SHALL make the frame length exactly (WIDTH+2)*DIV cycles; with DIV=1 the bit counter alone sequences bits and the divider is bypassed.
REQ-022 SHALL use a bit-divider counter of width clog2(DIV) that wraps to 0 at DIV-1 and never overflows.

Reset
REQ-023 SHALL, on rst assertion, immediately put the FSM in IDLE, tx_bit=1, tx_active=0, req_ready=0, grant_id=0, and last_grant=NREQ-1 (so requester 0 has first priority), including mid-frame.
REQ-024 SHALL discard any in-flight frame on reset, and SHALL make the first accept after rst deassertion no earlier than the first rising edge of clk.

Structure
REQ-025 SHALL place the FSM state enum and the START_BIT/STOP_BIT/IDLE_LEVEL constants in shared package lvds_tx_pkg.
REQ-026 SHALL instantiate the shift/divider datapath as sub-module lvds_tx_ser (load, data, tx_bit, last_cycle); arbitration and the FSM SHALL stay in the top module.
REQ-027 SHALL add no cross-clock logic; all logic is in the clk domain.

Verification
REQ-028 Single frame: NREQ=2, WIDTH=8, DIV=4, req_valid=01, data0=0xA5 -> req_ready=01 for one cycle; tx_bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_active high 40 cycles; grant_id=0.
REQ-029 Contention: both valid continuously, data0=0x11, data1=0x22 -> frames alternate 0,1,0,1 with zero-gap back-to-back; grant_id alternates 0,1.
REQ-030 DIV=1, WIDTH=1, data=1 -> tx_bit 0,1,1 over 3 cycles, then idle at 1.
REQ-031 Reset mid-DATA (cycle 15 of a frame) -> tx_bit=1 and tx_active=0 without waiting for clk; after release, requester 0 wins over requester 1 when both are valid.
REQ-032 Valid pulse during a frame: req_valid[1] high for 3 cycles inside DATA only -> no req_ready[1], no extra frame.
REQ-033 NREQ=4, only req 3 and req 1 valid, last_grant=1 -> req 3 is granted first, then req 1.
